arbitro_extensor: RTL and testbench
===================================

ARBITRO_EXTENSOR -- requirements
Module: arbitro_extensor

Interface
REQ-001 Parameter PRIO_INICIAL, default 0: requester given priority after reset (0 = requester 0, 1 = requester 1).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 req0  input  1  requester 0 (ALU immediate path) requests a 16-bit extension.
REQ-005 dado0  input  16  requester 0 operand.
REQ-006 req1  input  1  requester 1 (branch offset path) requests a 21-bit extension.
REQ-007 dado1  input  21  requester 1 operand.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulses; at most one high per cycle.
REQ-009 ext_in16  output  16  operand to shared extender, 16-bit port.
REQ-010 ext_in21  output  21  operand to shared extender, 21-bit port.
REQ-011 ext_ctrl  output  1  extender select: 1 = 16-bit, 0 = 21-bit.
REQ-012 ext_extendido  input  32  combinational result returned by the shared extender.
REQ-013 resultado  output  32  registered extended value.
REQ-014 valido  output  1  resultado valid.
REQ-015 dono  output  1  requester owning current resultado (0 or 1).
REQ-016 aceito  input  1  consumer accepts resultado.
REQ-017 conta_servicos  output  8  count of completed transactions.

Function
REQ-018 FSM states OCIOSO, EXTENDE, ENTREGA; all outputs registered.
REQ-019 OCIOSO: if no request, stay; if exactly one request, select it; if both, select the requester not served most recently (after reset, PRIO_INICIAL).
REQ-020 On selection edge: latch selected operand, set dono, pulse matching gnt for the following cycle only, go to EXTENDE.
REQ-021 Requesters hold req and data stable until they see gnt; data is sampled on the selection edge only.
REQ-022 While not in EXTENDE/ENTREGA with a held operand, ext_in16, ext_in21 = 0 and ext_ctrl = 1.
REQ-023 From selection until return to OCIOSO: dono=0 drives ext_in16=latched operand, ext_in21=0, ext_ctrl=1; dono=1 drives ext_in21=latched operand, ext_in16=0, ext_ctrl=0.
REQ-024 EXTENDE: capture ext_extendido into resultado, set valido, go to ENTREGA (exactly one cycle).
REQ-025 Latency: request sampled at edge N -> gnt high cycle N+1 -> valido high from edge N+2.
REQ-026 ENTREGA: hold resultado, dono, valido until aceito sampled high; on that edge clear valido, record dono as last served, increment conta_servicos, go to OCIOSO.
REQ-027 Minimum 3 cycles between successive grants; no grant issued while valido high.
REQ-028 aceito while valido low is ignored; requests arriving or dropping in EXTENDE/ENTREGA are ignored until OCIOSO.
REQ-029 conta_servicos wraps 255 -> 0 without flag.
REQ-030 Expected resultado equals two's-complement sign extension of the latched operand to 32 bits; the block passes ext_extendido through unmodified.

Reset
REQ-031 reset high at a rising edge, in any state: state OCIOSO, gnt0=gnt1=0, valido=0, resultado=0, dono=0, conta_servicos=0, last-served pointer per PRIO_INICIAL, extender outputs to idle values of REQ-022.
REQ-032 reset mid-transaction discards the pending result; no grant is re-issued unless the request is still held after reset is released.

Verification
REQ-033 Single req0, dado0=16'h8001, aceito high -> gnt0 cycle N+1, ext_ctrl=1, resultado=32'hFFFF8001, dono=0 at N+2, conta_servicos=1.
REQ-034 Single req1, dado1=21'h0FFFF -> ext_ctrl=0, resultado=32'h0000FFFF; dado1=21'h100000 -> resultado=32'hFFF00000.
REQ-035 req0 and req1 held continuously, aceito always high -> grants alternate 0,1,0,1 (PRIO_INICIAL=0), one grant every 3 cycles.
REQ-036 aceito held low 5 cycles in ENTREGA -> valido and resultado stable, no gnt, no count change; release -> OCIOSO next cycle.
REQ-037 reset asserted in EXTENDE and in ENTREGA -> all outputs at REQ-031 values next cycle, conta_servicos=0.
REQ-038 256 completed transactions -> conta_servicos returns to 0.

Source files
------------

// File: rtl/arbitro_extensor.sv
// Two-requester arbiter sharing one sign extender (16-bit ALU imm, 21-bit branch offset).
// Fair alternation under contention; result held until the consumer accepts it.
module arbitro_extensor #(
  parameter bit PRIO_INICIAL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] dado0,
  input  logic        req1,
  input  logic [20:0] dado1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] ext_in16,
  output logic [20:0] ext_in21,
  output logic        ext_ctrl,
  input  logic [31:0] ext_extendido,
  output logic [31:0] resultado,
  output logic        valido,
  output logic        dono,
  input  logic        aceito,
  output logic [7:0]  conta_servicos
);

  typedef enum logic [1:0] {
    OCIOSO,
    EXTENDE,
    ENTREGA
  } estado_t;

  estado_t estado;
  logic    ultimo;
  logic    escolhe1;

  // requester 1 wins alone, or on contention when 0 was served last
  always_comb begin
    escolhe1 = req1 && (!req0 || !ultimo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= OCIOSO;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      valido         <= 1'b0;
      resultado      <= '0;
      dono           <= 1'b0;
      conta_servicos <= '0;
      ultimo         <= ~PRIO_INICIAL;
      ext_in16       <= '0;
      ext_in21       <= '0;
      ext_ctrl       <= 1'b1;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (req0 || req1) begin
            estado <= EXTENDE;
            if (escolhe1) begin
              gnt1     <= 1'b1;
              dono     <= 1'b1;
              ext_in16 <= '0;
              ext_in21 <= dado1;
              ext_ctrl <= 1'b0;
            end else begin
              gnt0     <= 1'b1;
              dono     <= 1'b0;
              ext_in16 <= dado0;
              ext_in21 <= '0;
              ext_ctrl <= 1'b1;
            end
          end
        end
        EXTENDE: begin
          resultado <= ext_extendido;
          valido    <= 1'b1;
          estado    <= ENTREGA;
        end
        ENTREGA: begin
          if (aceito) begin
            valido         <= 1'b0;
            ultimo         <= dono;
            conta_servicos <= conta_servicos + 8'd1;
            ext_in16       <= '0;
            ext_in21       <= '0;
            ext_ctrl       <= 1'b1;
            estado         <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_extensor.sv
// Bench for arbitro_extensor: transaction model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_arbitro_extensor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic [15:0] dado0 = '0;
  logic        req1 = 1'b0;
  logic [20:0] dado1 = '0;
  logic        gnt0, gnt1;
  logic [15:0] ext_in16;
  logic [20:0] ext_in21;
  logic        ext_ctrl;
  logic [31:0] ext_extendido;
  logic [31:0] resultado;
  logic        valido, dono;
  logic        aceito = 1'b1;
  logic [7:0]  conta_servicos;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  arbitro_extensor #(.PRIO_INICIAL(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .dado0(dado0),
    .req1(req1), .dado1(dado1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ext_in16(ext_in16), .ext_in21(ext_in21),
    .ext_ctrl(ext_ctrl), .ext_extendido(ext_extendido),
    .resultado(resultado), .valido(valido), .dono(dono),
    .aceito(aceito), .conta_servicos(conta_servicos)
  );

  function automatic logic [31:0] sext(input bit w, input logic [20:0] op);
    if (w) return {{11{op[20]}}, op};
    return {{16{op[15]}}, op[15:0]};
  endfunction

  // the shared extender as seen by the block
  assign ext_extendido = ext_ctrl ? sext(1'b0, {5'd0, ext_in16})
                                  : sext(1'b1, ext_in21);

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask

  // transaction model: one pending transaction, age in cycles since grant
  bit          m_busy = 0;
  int          m_age = 0;
  bit          m_who = 0;
  logic [20:0] m_op = '0;
  logic [31:0] m_res = '0;
  bit          m_last = 1;
  int          m_count = 0;
  int          cyc = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_busy = 0; m_age = 0; m_who = 0; m_op = '0;
      m_res = '0; m_last = 1; m_count = 0;
    end else if (m_busy) begin
      if (m_age == 0) begin
        m_res = sext(m_who, m_op);
        m_age = 1;
      end else if (aceito) begin
        m_busy = 0;
        m_last = m_who;
        m_count = (m_count + 1) % 256;
      end else begin
        m_age++;
      end
    end else if (req0 || req1) begin
      m_who = (req0 && req1) ? !m_last : req1;
      m_op = m_who ? dado1 : {5'd0, dado0};
      m_busy = 1;
      m_age = 0;
    end
  end

  bit chk_on = 0;
  int gq_who[$];
  int gq_cyc[$];
  int n_g0 = 0;

  always @(negedge clock) begin
    if (chk_on) begin
      bit g_now;
      g_now = m_busy && (m_age == 0);
      chk("gnt0", {31'd0, gnt0}, {31'd0, g_now && !m_who});
      chk("gnt1", {31'd0, gnt1}, {31'd0, g_now && m_who});
      chk("valido", {31'd0, valido}, {31'd0, m_busy && m_age >= 1});
      chk("dono", {31'd0, dono}, {31'd0, m_who});
      chk("resultado", resultado, m_res);
      chk("conta", {24'd0, conta_servicos}, m_count);
      chk("ext_ctrl", {31'd0, ext_ctrl}, {31'd0, !(m_busy && m_who)});
      chk("ext_in16", {16'd0, ext_in16},
          (m_busy && !m_who) ? {16'd0, m_op[15:0]} : 32'd0);
      chk("ext_in21", {11'd0, ext_in21},
          (m_busy && m_who) ? {11'd0, m_op} : 32'd0);
      if (gnt0 || gnt1) begin
        gq_who.push_back(gnt1 ? 1 : 0);
        gq_cyc.push_back(cyc);
      end
      if (gnt0) n_g0++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // single request; literal expectations for grant and result
  task automatic um(input bit r, input logic [20:0] d,
                    input logic [31:0] exp_res, input string n);
    if (r) begin req1 = 1; dado1 = d; end
    else begin req0 = 1; dado0 = d[15:0]; end
    tick();
    req0 = 0; req1 = 0;
    @(negedge clock);
    chk({n, "_gnt"}, {30'd0, gnt1, gnt0}, r ? 32'd2 : 32'd1);
    chk({n, "_ctrl"}, {31'd0, ext_ctrl}, {31'd0, !r});
    @(negedge clock);
    chk({n, "_res"}, resultado, exp_res);
    chk({n, "_dono"}, {30'd0, valido, dono}, {30'd0, 1'b1, r});
    tick();
  endtask

  int c0;

  initial begin
    tick();
    chk_on = 1;
    tick();
    reset = 0;
    @(negedge clock);
    chk("rst_conta", {24'd0, conta_servicos}, 32'd0);
    chk("rst_ctrl", {31'd0, ext_ctrl}, 32'd1);
    tick();

    um(0, 21'h08001, 32'hFFFF8001, "r0_8001");
    @(negedge clock);
    chk("conta_1", {24'd0, conta_servicos}, 32'd1);
    tick();
    um(1, 21'h0FFFF, 32'h0000FFFF, "r1_0ffff");
    um(1, 21'h100000, 32'hFFF00000, "r1_100000");
    um(0, 21'h00123, 32'h00000123, "r0_0123");

    // contention: last served was 0, so expect 1,0,1,0
    gq_who.delete(); gq_cyc.delete();
    req0 = 1; dado0 = 16'hA5A5;
    req1 = 1; dado1 = 21'h1ABCDE;
    repeat (11) tick();
    req0 = 0; req1 = 0;
    repeat (3) tick();
    chk("alt_n", gq_who.size(), 32'd4);
    if (gq_who.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("alt_who", gq_who[i], (i % 2 == 0) ? 32'd1 : 32'd0);
        if (i > 0) chk("alt_gap", gq_cyc[i] - gq_cyc[i-1], 32'd3);
      end
    end

    // consumer stalls five cycles
    aceito = 0;
    c0 = conta_servicos;
    req0 = 1; dado0 = 16'h7FFF;
    tick();
    req0 = 0;
    tick();
    req1 = 1; dado1 = 21'h00042;
    repeat (5) tick();
    @(negedge clock);
    chk("stall_val", {31'd0, valido}, 32'd1);
    chk("stall_res", resultado, 32'h00007FFF);
    chk("stall_conta", {24'd0, conta_servicos}, c0);
    aceito = 1;
    tick();
    req1 = 0;
    @(negedge clock);
    chk("stall_rel", {31'd0, valido}, 32'd0);
    chk("stall_c1", {24'd0, conta_servicos}, (c0 + 1) % 256);
    repeat (4) tick();

    // reset during EXTENDE
    req1 = 1; dado1 = 21'h00007;
    tick();
    req1 = 0; reset = 1;
    tick();
    reset = 0;
    @(negedge clock);
    chk("rstx_conta", {24'd0, conta_servicos}, 32'd0);
    chk("rstx_out", {28'd0, gnt0, gnt1, valido, ext_ctrl}, 32'd1);
    chk("rstx_res", resultado, 32'd0);
    tick();

    // reset during ENTREGA
    aceito = 0;
    req0 = 1; dado0 = 16'h8000;
    tick();
    req0 = 0;
    repeat (2) tick();
    reset = 1;
    tick();
    reset = 0; aceito = 1;
    @(negedge clock);
    chk("rste_out", {27'd0, gnt0, gnt1, valido, dono, ext_ctrl}, 32'd1);
    chk("rste_conta", {24'd0, conta_servicos}, 32'd0);
    tick();

    // wraparound after 256 transactions
    n_g0 = 0;
    req0 = 1; dado0 = 16'h1234;
    for (int k = 0; k < 1000 && n_g0 < 256; k++) @(negedge clock);
    chk("wrap_grants", n_g0, 32'd256);
    tick();
    req0 = 0;
    repeat (4) tick();
    @(negedge clock);
    chk("wrap_conta", {24'd0, conta_servicos}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
